// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus types used by the cbus converters, the arbiter and the memory side.
package cbus_arbiter_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Encoded as beats-1, matching AXI AxLEN.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_type_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    addr_t           addr;
    strobe_t         strobe;
    word_t           data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

  function automatic int unsigned wrap_next(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/cbus_arbiter_rr_select.sv
// Combinational rotating-priority pick: first valid index scanning from ptr upward with wrap.
module rr_select #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!any_valid && valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Registered IDLE/BUSY arbiter muxing NUM_MASTERS cbus requesters onto one downstream port.
// Grant appears one cycle after request; one idle bubble follows every last beat.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_MASTERS],
  output cbus_resp_t iresps [NUM_MASTERS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   index, index_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic               busy;
  logic [NUM_MASTERS-1:0] valid_vec;
  logic [IDX_W-1:0]   sel_ptr;
  logic [IDX_W-1:0]   winner;
  logic               any_valid;

  assign busy = (state == BUSY);

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      valid_vec[i] = ireqs[i].valid;
    end
  end

  // Fixed priority is the same scan anchored at index 0.
  assign sel_ptr = ROUND_ROBIN ? rr_ptr : '0;

  rr_select #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .valid     (valid_vec),
    .ptr       (sel_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    state_nxt  = state;
    index_nxt  = index;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt = BUSY;
          index_nxt = winner;
          if (ROUND_ROBIN) begin
            rr_ptr_nxt = IDX_W'(wrap_next(int'(winner), NUM_MASTERS));
          end
        end
      end
      BUSY: begin
        if (oresp.ready && oresp.last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      index  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      index  <= index_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Request and response paths stay combinational so write data/strobe can change per beat.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      iresps[i] = '0;
    end
    if (!reset && busy) begin
      oreq          = ireqs[index];
      iresps[index] = oresp;
    end
  end

  a_index_range : assert property (@(posedge clk) disable iff (reset)
    busy |-> (int'(index) < NUM_MASTERS));

  a_ptr_range : assert property (@(posedge clk) disable iff (reset)
    int'(rr_ptr) < NUM_MASTERS);

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share stimulus; vectors and corner sequences.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  logic       clk;
  logic       reset;
  cbus_req_t  ireqs [2];
  cbus_resp_t oresp;
  cbus_resp_t iresps_rr [2];
  cbus_resp_t iresps_fx [2];
  cbus_req_t  oreq_rr;
  cbus_req_t  oreq_fx;

  int nvec  = 0;
  int nfail = 0;

  cbus_arbiter #(.NUM_MASTERS(2), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk    (clk),
    .reset  (reset),
    .ireqs  (ireqs),
    .iresps (iresps_rr),
    .oreq   (oreq_rr),
    .oresp  (oresp)
  );

  cbus_arbiter #(.NUM_MASTERS(2), .ROUND_ROBIN(1'b0)) dut_fx (
    .clk    (clk),
    .reset  (reset),
    .ireqs  (ireqs),
    .iresps (iresps_fx),
    .oreq   (oreq_fx),
    .oresp  (oresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // osrc: 0 = oreq zero, 1/2 = ireqs[0]/[1]; rsel: 0 = no response routed, 1/2 = to master 0/1.
  typedef struct {
    bit    fx;
    bit    v0;
    bit    v1;
    mlen_t l0;
    mlen_t l1;
    bit    rdy;
    bit    lst;
    int    osrc;
    int    rsel;
    bit    ebusy;
    int    eptr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(bit fx, bit v0, bit v1, mlen_t l0, mlen_t l1, bit rdy, bit lst,
                               int osrc, int rsel, bit ebusy, int eptr);
    vec_t v;
    v.fx = fx; v.v0 = v0; v.v1 = v1; v.l0 = l0; v.l1 = l1; v.rdy = rdy; v.lst = lst;
    v.osrc = osrc; v.rsel = rsel; v.ebusy = ebusy; v.eptr = eptr;
    return v;
  endfunction

  function automatic cbus_req_t mk_req(int m, bit v, bit wr, mlen_t len, word_t data);
    cbus_req_t r;
    r          = '0;
    r.valid    = v;
    r.is_write = wr;
    r.size     = MSIZE4;
    r.addr     = (m == 0) ? 32'h1fc0_0000 : 32'h8000_1000;
    r.strobe   = wr ? 8'hff : 8'h00;
    r.data     = data;
    r.len      = len;
    r.burst    = AXI_BURST_INCR;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ireqs[0] = '0;
    ireqs[1] = '0;
    oresp = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vec_t       v;
    cbus_req_t  exp_req;
    cbus_resp_t exp_r0, exp_r1;
    cbus_req_t  act_req;
    cbus_resp_t act_r0, act_r1;
    logic       act_busy;
    logic       act_ptr;
    int         beats;
    bit         done;
    bit         rdy;

    reset = 1'b1;
    ireqs[0] = mk_req(0, 1'b1, 1'b0, MLEN4, '0);
    ireqs[1] = mk_req(1, 1'b1, 1'b0, MLEN4, '0);
    oresp = '{ready: 1'b1, last: 1'b1, data: 64'hdead};
    tick();
    tick();
    @(negedge clk);
    chk("rst_oreq",    128'(oreq_rr),      128'(0));
    chk("rst_iresp0",  128'(iresps_rr[0]), 128'(0));
    chk("rst_iresp1",  128'(iresps_rr[1]), 128'(0));
    chk("rst_busy",    128'(dut_rr.busy),  128'(0));
    chk("rst_ptr",     128'(dut_rr.rr_ptr),128'(0));
    chk("rst_oreq_fx", 128'(oreq_fx),      128'(0));

    // Round-robin: single master, then simultaneous 4-beat reads, then master 0 again.
    vecs.push_back(mkv(0, 0, 1, MLEN1, MLEN1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 1, MLEN1, MLEN1, 1, 1, 2, 2, 1, 0));
    vecs.push_back(mkv(0, 0, 0, MLEN1, MLEN1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 1, MLEN4, MLEN4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 1, MLEN4, MLEN4, 1, 0, 1, 1, 1, 1));
    vecs.push_back(mkv(0, 1, 1, MLEN4, MLEN4, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mkv(0, 1, 1, MLEN4, MLEN4, 1, 0, 1, 1, 1, 1));
    vecs.push_back(mkv(0, 1, 1, MLEN4, MLEN4, 1, 1, 1, 1, 1, 1));
    vecs.push_back(mkv(0, 1, 1, MLEN1, MLEN4, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(0, 1, 1, MLEN1, MLEN4, 1, 0, 2, 2, 1, 0));
    vecs.push_back(mkv(0, 1, 1, MLEN1, MLEN4, 1, 0, 2, 2, 1, 0));
    vecs.push_back(mkv(0, 1, 1, MLEN1, MLEN4, 1, 0, 2, 2, 1, 0));
    vecs.push_back(mkv(0, 1, 1, MLEN1, MLEN4, 1, 1, 2, 2, 1, 0));
    vecs.push_back(mkv(0, 1, 0, MLEN1, MLEN1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 0, MLEN1, MLEN1, 1, 1, 1, 1, 1, 1));
    vecs.push_back(mkv(0, 0, 0, MLEN1, MLEN1, 1, 1, 0, 0, 0, 1));
    // Fixed priority: master 0 takes three transactions before master 1 gets any.
    vecs.push_back(mkv(1, 1, 1, MLEN1, MLEN1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 1, MLEN1, MLEN1, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mkv(1, 1, 1, MLEN1, MLEN1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 1, MLEN1, MLEN1, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mkv(1, 1, 1, MLEN1, MLEN1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 1, MLEN1, MLEN1, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mkv(1, 0, 1, MLEN1, MLEN1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 0, 1, MLEN1, MLEN1, 1, 1, 2, 2, 1, 0));
    vecs.push_back(mkv(1, 0, 1, MLEN1, MLEN1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 0, 1, MLEN1, MLEN1, 1, 1, 2, 2, 1, 0));
    vecs.push_back(mkv(1, 0, 1, MLEN1, MLEN1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 0, 1, MLEN1, MLEN1, 1, 1, 2, 2, 1, 0));
    vecs.push_back(mkv(1, 0, 0, MLEN1, MLEN1, 0, 0, 0, 0, 0, 0));

    do_reset();
    for (int n = 0; n < vecs.size(); n++) begin
      v = vecs[n];
      if (n == 16) do_reset();
      ireqs[0]    = mk_req(0, v.v0, 1'b0, v.l0, '0);
      ireqs[1]    = mk_req(1, v.v1, 1'b0, v.l1, '0);
      oresp.ready = v.rdy;
      oresp.last  = v.lst;
      oresp.data  = 64'hd000 + 64'(n);
      @(negedge clk);
      exp_req = (v.osrc == 0) ? cbus_req_t'('0) : ireqs[v.osrc - 1];
      exp_r0  = (v.rsel == 1) ? oresp : cbus_resp_t'('0);
      exp_r1  = (v.rsel == 2) ? oresp : cbus_resp_t'('0);
      act_req  = v.fx ? oreq_fx       : oreq_rr;
      act_r0   = v.fx ? iresps_fx[0]  : iresps_rr[0];
      act_r1   = v.fx ? iresps_fx[1]  : iresps_rr[1];
      act_busy = v.fx ? dut_fx.busy   : dut_rr.busy;
      act_ptr  = v.fx ? dut_fx.rr_ptr : dut_rr.rr_ptr;
      chk($sformatf("vec%0d_oreq", n),   128'(act_req),  128'(exp_req));
      chk($sformatf("vec%0d_iresp0", n), 128'(act_r0),   128'(exp_r0));
      chk($sformatf("vec%0d_iresp1", n), 128'(act_r1),   128'(exp_r1));
      chk($sformatf("vec%0d_busy", n),   128'(act_busy), 128'(v.ebusy));
      chk($sformatf("vec%0d_ptr", n),    128'(act_ptr),  128'(v.eptr));
      tick();
    end

    // Write burst on master 1 with per-beat data; master 0 arrives mid-burst and must wait.
    do_reset();
    ireqs[1] = mk_req(1, 1'b1, 1'b1, MLEN4, 64'h11);
    @(negedge clk);
    chk("wr_idle_oreq", 128'(oreq_rr), 128'(0));
    tick();
    ireqs[0] = mk_req(0, 1'b1, 1'b0, MLEN1, '0);
    for (int b = 0; b < 4; b++) begin
      ireqs[1].data = 64'h11 * 64'(b + 1);
      oresp.ready   = 1'b1;
      oresp.last    = (b == 3);
      oresp.data    = 64'hb0 + 64'(b);
      @(negedge clk);
      chk($sformatf("wr_b%0d_data", b),   128'(oreq_rr.data),        128'(64'h11 * 64'(b + 1)));
      chk($sformatf("wr_b%0d_oreq", b),   128'(oreq_rr),             128'(ireqs[1]));
      chk($sformatf("wr_b%0d_iresp0", b), 128'(iresps_rr[0]),        128'(0));
      chk($sformatf("wr_b%0d_rdy1", b),   128'(iresps_rr[1].ready),  128'(1));
      tick();
    end
    ireqs[1].valid = 1'b0;
    oresp = '0;
    @(negedge clk);
    chk("wr_done_busy", 128'(dut_rr.busy), 128'(0));
    chk("wr_done_oreq", 128'(oreq_rr),     128'(0));
    tick();
    @(negedge clk);
    chk("wr_next_grant", 128'(oreq_rr), 128'(ireqs[0]));
    oresp = '{ready: 1'b1, last: 1'b1, data: 64'h5};
    tick();
    ireqs[0] = '0;
    oresp = '0;

    // Reset during beat 2 of a 4-beat read, then a fresh request.
    do_reset();
    ireqs[0] = mk_req(0, 1'b1, 1'b0, MLEN4, '0);
    tick();
    oresp = '{ready: 1'b1, last: 1'b0, data: 64'h1};
    @(negedge clk);
    chk("rb_beat1_rdy0", 128'(iresps_rr[0].ready), 128'(1));
    tick();
    reset = 1'b1;
    oresp.data = 64'h2;
    tick();
    reset = 1'b0;
    ireqs[0] = '0;
    oresp = '{ready: 1'b1, last: 1'b1, data: 64'h3};
    @(negedge clk);
    chk("rb_oreq",   128'(oreq_rr),       128'(0));
    chk("rb_iresp0", 128'(iresps_rr[0]),  128'(0));
    chk("rb_iresp1", 128'(iresps_rr[1]),  128'(0));
    chk("rb_busy",   128'(dut_rr.busy),   128'(0));
    chk("rb_ptr",    128'(dut_rr.rr_ptr), 128'(0));
    tick();
    ireqs[1] = mk_req(1, 1'b1, 1'b0, MLEN1, '0);
    oresp = '0;
    tick();
    oresp = '{ready: 1'b1, last: 1'b1, data: 64'h4};
    @(negedge clk);
    chk("rb_fresh_oreq",   128'(oreq_rr),      128'(ireqs[1]));
    chk("rb_fresh_iresp1", 128'(iresps_rr[1]), 128'(oresp));
    tick();
    ireqs[1] = '0;
    oresp = '0;

    // Response isolation: ready pulses while master 0 holds the grant and master 1 waits.
    do_reset();
    ireqs[0] = mk_req(0, 1'b1, 1'b0, MLEN4, '0);
    ireqs[1] = mk_req(1, 1'b1, 1'b0, MLEN1, '0);
    tick();
    beats = 0;
    done  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (!done) begin
        rdy = (c % 2 == 0);
        oresp.ready = rdy;
        oresp.last  = rdy && (beats == 3);
        oresp.data  = 64'hc0 + 64'(c);
        @(negedge clk);
        chk($sformatf("iso_c%0d_rdy1", c), 128'(iresps_rr[1].ready), 128'(0));
        chk($sformatf("iso_c%0d_rdy0", c), 128'(iresps_rr[0].ready), 128'(rdy));
        if (oresp.last) done = 1'b1;
        if (rdy) beats++;
        tick();
      end
    end
    chk("iso_beats", 128'(beats), 128'(4));
    ireqs[0] = '0;
    oresp = '{ready: 1'b1, last: 1'b0, data: 64'he0};
    @(negedge clk);
    chk("iso_idle_rdy1", 128'(iresps_rr[1].ready), 128'(0));
    tick();
    oresp = '{ready: 1'b1, last: 1'b1, data: 64'he1};
    @(negedge clk);
    chk("iso_grant_rdy1", 128'(iresps_rr[1].ready), 128'(1));
    chk("iso_grant_rdy0", 128'(iresps_rr[0].ready), 128'(0));
    tick();
    ireqs[1] = '0;
    oresp = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
